// File: rtl/dram_responder_if.sv
// Host/accelerator bus bundle for dram_responder.
// The DUT connects through the slave modport; the driver side uses master.
interface dram_responder_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
);
  logic [1:0]        cmd;
  logic              hostWrEn;
  logic [ADDR_W-1:0] hostAddr;
  logic [DATA_W-1:0] hostData;
  logic              DRAMreadEn;
  logic [ADDR_W-1:0] DRAMreadAddr;
  logic [DATA_W-1:0] ifmap;
  logic              ifmapValid;
  logic              DRAMwriteEn;
  logic [ADDR_W-1:0] DRAMwriteAddr;
  logic [DATA_W-1:0] DRAMwriteData;
  logic [1:0]        state;
  logic [ADDR_W:0]   writeCount;
  logic              done;
  logic              protErr;

  modport master (
    output cmd, hostWrEn, hostAddr, hostData,
    output DRAMreadEn, DRAMreadAddr, DRAMwriteEn, DRAMwriteAddr, DRAMwriteData,
    input  ifmap, ifmapValid, state, writeCount, done, protErr
  );

  modport slave (
    input  cmd, hostWrEn, hostAddr, hostData,
    input  DRAMreadEn, DRAMreadAddr, DRAMwriteEn, DRAMwriteAddr, DRAMwriteData,
    output ifmap, ifmapValid, state, writeCount, done, protErr
  );
endinterface

// File: rtl/dram_responder.sv
// Behavioural DRAM model for an accelerator: host LOAD phase, RUN phase with
// a fixed-latency read pipeline, write counting and protection-error tracking.
module dram_responder #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 1,
  parameter int OUT_WORDS = 256
) (
  input logic             clk,
  input logic             rst,
  dram_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] OUT_CNT = (ADDR_W + 1)'(OUT_WORDS);
  localparam logic [ADDR_W:0] ONE_CNT = (ADDR_W + 1)'(1);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_RUN   = 2'd2;
  localparam logic [1:0] CMD_ABORT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              done_q, done_d;
  logic              perr_q, perr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_acc, wr_acc, host_acc, run_end, acc_err, host_err;

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] data_q   [RD_LAT];
  logic [RD_LAT-1:0] stg_vld;
  logic [DATA_W-1:0] stg_data [RD_LAT];

  assign rd_acc   = (state_q == RUN)  && bus.DRAMreadEn;
  assign wr_acc   = (state_q == RUN)  && bus.DRAMwriteEn;
  assign host_acc = (state_q == LOAD) && bus.hostWrEn;
  assign acc_err  = (state_q != RUN)  && (bus.DRAMreadEn || bus.DRAMwriteEn);
  assign host_err = (state_q != LOAD) && bus.hostWrEn;
  assign run_end  = wr_acc && ((wcnt_q + ONE_CNT) == OUT_CNT);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    perr_d  = perr_q | acc_err | host_err;
    case (state_q)
      IDLE: begin
        if (bus.cmd == CMD_LOAD) begin
          state_d = LOAD;
        end else if (bus.cmd == CMD_RUN) begin
          state_d = RUN;
          wcnt_d  = '0;
        end
      end
      LOAD: begin
        if (bus.cmd == CMD_NONE || bus.cmd == CMD_ABORT) state_d = IDLE;
      end
      RUN: begin
        if (wr_acc) wcnt_d = wcnt_q + ONE_CNT;
        // A completing write wins over a same-cycle ABORT so the run is not lost.
        if (run_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (bus.cmd == CMD_ABORT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      vld_q   <= stg_vld;
    end
  end

  // Memory writes are non-blocking, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (host_acc) begin
      mem[bus.hostAddr] <= bus.hostData;
    end else if (wr_acc) begin
      mem[bus.DRAMwriteAddr] <= bus.DRAMwriteData;
    end
  end

  // Stage 0 samples the array; later stages shift; each stage holds when idle.
  always_comb begin
    stg_vld[0]  = rd_acc;
    stg_data[0] = mem[bus.DRAMreadAddr];
    for (int k = 1; k < RD_LAT; k++) begin
      stg_vld[k]  = vld_q[k-1];
      stg_data[k] = data_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < RD_LAT; k++) begin
      if (stg_vld[k]) data_q[k] <= stg_data[k];
    end
    if (rst) data_q[RD_LAT-1] <= '0;
  end

  assign bus.ifmap      = data_q[RD_LAT-1];
  assign bus.ifmapValid = vld_q[RD_LAT-1];
  assign bus.state      = state_q;
  assign bus.writeCount = wcnt_q;
  assign bus.done       = done_q;
  assign bus.protErr    = perr_q;
endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 Parameter DATA_W, default 64, memory word width.
REQ-002 Parameter ADDR_W, default 10, word address width; depth = 2^ADDR_W.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-004 Parameter OUT_WORDS, default 256, number of accelerator writes that ends a run.
REQ-005 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port cmd, input, 2, host command: 0 = none, 1 = LOAD, 2 = RUN, 3 = ABORT.
REQ-008 Port hostWrEn, input, 1, host write strobe; honoured in LOAD only.
REQ-009 Port hostAddr, input, ADDR_W, host write address.
REQ-010 Port hostData, input, DATA_W, host write data.
REQ-011 Port DRAMreadEn, input, 1, accelerator read request.
REQ-012 Port DRAMreadAddr, input, ADDR_W, accelerator read address.
REQ-013 Port ifmap, output, DATA_W, read data returned to the accelerator.
REQ-014 Port ifmapValid, output, 1, ifmap carries the data of a request.
REQ-015 Port DRAMwriteEn, input, 1, accelerator write strobe.
REQ-016 Port DRAMwriteAddr, input, ADDR_W, accelerator write address.
REQ-017 Port DRAMwriteData, input, DATA_W, accelerator write data.
REQ-018 Port state, output, 2, FSM state: 0 = IDLE, 1 = LOAD, 2 = RUN.
REQ-019 Port writeCount, output, ADDR_W+1, accelerator writes accepted in the current run.
REQ-020 Port done, output, 1, one-cycle pulse at the end of a run.
REQ-021 Port protErr, output, 1, sticky flag set by an access outside RUN.

Function
REQ-022 FSM transitions: IDLE -> LOAD on cmd=1; IDLE -> RUN on cmd=2; LOAD -> IDLE on cmd=0 or 3; RUN -> IDLE on cmd=3 or when the run completes (REQ-028); any other cmd value leaves the state unchanged.
REQ-023 A host write in LOAD writes hostData to mem[hostAddr] at the clock edge where hostWrEn is high.
REQ-024 A read in RUN issued with DRAMreadEn high at edge N drives ifmap = mem[DRAMreadAddr] and ifmapValid = 1 for exactly one cycle, at edge N+RD_LAT.
REQ-025 The read pipeline accepts one request per cycle, back-to-back, with no stall and no reordering.
REQ-026 An accelerator write in RUN writes DRAMwriteData to mem[DRAMwriteAddr] and increments writeCount by 1.
REQ-027 A read and a write to the same address at the same edge are read-first: the read returns the old word.
REQ-028 When the write taking writeCount to OUT_WORDS is accepted, the next edge enters IDLE and pulses done for one cycle.
REQ-029 Entering RUN clears writeCount to 0; leaving RUN holds writeCount, so the host can read it.
REQ-030 An accelerator read or write outside RUN is ignored: no memory change, no ifmapValid; it sets protErr.
REQ-031 A host write outside LOAD is ignored and sets protErr; protErr clears only on rst.
REQ-032 ABORT in RUN: the FSM enters IDLE on the next edge; reads already in flight still complete on schedule; done is not pulsed.
REQ-033 ifmap holds its last value while ifmapValid is low.

Reset
REQ-034 On rst high at a clock edge: state = IDLE, writeCount = 0, done = 0, protErr = 0, ifmap = 0, ifmapValid = 0, and the read pipeline is flushed.
REQ-035 Memory contents are not reset and survive rst.
REQ-036 rst mid-RUN discards in-flight reads: no ifmapValid is produced after the reset edge.

Verification
REQ-037 LOAD mem[5] = 0xA5A5_0000_0000_0001, then RUN with a read of address 5 at edge N -> ifmap = 0xA5A5_0000_0000_0001 and ifmapValid = 1 at edge N+RD_LAT (check with RD_LAT = 1 and RD_LAT = 3).
REQ-038 Back-to-back reads of addresses 0..7 in RUN -> eight consecutive valid words, in order, with no bubble.
REQ-039 Same-edge read and write of address 9 (old 0x11, new 0x22) -> the read returns 0x11; a later read returns 0x22.
REQ-040 OUT_WORDS = 4 and four writes -> done pulses once, state = IDLE, writeCount = 4; a fifth write is ignored and sets protErr.
REQ-041 ABORT with 2 reads in flight -> both still return valid data, state = IDLE, done stays 0.
REQ-042 rst with RD_LAT = 3 and reads in flight -> ifmapValid = 0 from the reset edge on, and memory data is intact afterwards.
